serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Multi-cycle unsigned/two's-complement subtractor, diff = a - b, processed DIGIT bits per clock, LSB digit first.
//  It is the inverse-operation companion to the combinational ripple-carry adder.
//  It sits on a valid/ready stream: it accepts one operand pair, computes over WIDTH/DIGIT cycles, and holds the result until consumed.
//  It is used where area matters more than latency, and as a cross-check against adder results (a + b - b == a).
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  DIGIT  4   bits processed per cycle; WIDTH % DIGIT == 0 required (elaboration-time check, $error if violated)
// PORTS
//  clk        input   1      clock, rising-edge
//  rst_n      input   1      asynchronous active-low reset
//  in_valid   input   1      operand pair a/b valid
//  in_ready   output  1      block can accept operands
//  a          input   WIDTH  minuend
//  b          input   WIDTH  subtrahend
//  out_valid  output  1      result valid; held until out_ready
//  out_ready  input   1      consumer accepts result
//  diff       output  WIDTH  (a - b) mod 2^WIDTH
//  borrow     output  1      1 iff a < b (unsigned)
//  ovf        output  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous): state=IDLE, digit count=0, in_ready=1, out_valid=0, diff=0, borrow=0, ovf=0.
//  - Let N = WIDTH/DIGIT. FSM states are IDLE, BUSY and DONE.
//  - IDLE: in_ready=1. On an edge with in_valid=1, latch a and b, set the internal borrow-in to 0, set count=0 and move to BUSY.
//  - BUSY: in_ready=0 and out_valid=0.
//    - Each edge computes diff digit[count] = a_dig - b_dig - bin with DIGIT-bit ripple borrow.
//    - The borrow-out is registered as the next cycle's bin, and count increments.
//    - On the edge where count==N-1: store the final borrow, compute ovf, and go to DONE.
//  - Latency: operands captured at edge E0; out_valid=1 after edge E0+N (N=8 by default). in_valid is ignored while not IDLE.
//  - DONE: out_valid=1. diff, borrow and ovf are stable and do not change while out_valid=1.
//    - On an edge with out_ready=1, go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
//    - diff, borrow and ovf keep their last values after leaving DONE until the next result is written.
//  - No same-cycle result pass-through: a new operand is accepted only in IDLE.
//    - Minimum initiation interval is N+2 cycles when out_ready is tied high.
//  - out_ready outside DONE has no effect. Inputs a/b are sampled only at the accept edge.
//    - Later changes to a/b during BUSY must not affect the result.
//  - Wrap-around: diff is modulo 2^WIDTH; borrow equals the final borrow-out of the MSB digit.
//  - Reset mid-operation (BUSY or DONE): the operation is abandoned immediately.
//    - All outputs return to their reset values; no partial result is ever presented.
//  - DIGIT==WIDTH is legal: N=1, one BUSY cycle.
// TESTING
//  1. a=5, b=3 -> after 8 cycles out_valid=1; diff=2, borrow=0, ovf=0.
//  2. a=0, b=1 -> diff=32'hFFFF_FFFF, borrow=1, ovf=0.
//  3. a=32'h8000_0000, b=1 -> diff=32'h7FFF_FFFF, borrow=0, ovf=1.
//     a=32'h7FFF_FFFF, b=32'hFFFF_FFFF -> diff=32'h8000_0000, borrow=1, ovf=1.
//  4. Backpressure: hold out_ready=0 for 5 cycles after out_valid.
//     -> out_valid, diff and borrow stay constant, and in_ready stays 0 even with in_valid=1.
//     Release -> IDLE next cycle.
//  5. Reset mid-op: assert rst_n=0 at BUSY count=3.
//     -> out_valid=0, in_ready=1 and diff=0 immediately.
//     Then a=100, b=40 -> diff=60 with no stale data.
//  6. Random: seed=0, 10 pairs of $random.
//     -> diff==a-b and borrow==(a<b) for each; repeat with DIGIT=1 and DIGIT=32.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial subtractor, diff = a - b, LSB digit first on a valid/ready stream
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_subtractor: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operands shift right one digit per cycle so the active digit is always at the bottom
  logic [WIDTH-1:0]       a_q, b_q;
  // Partial result; only copied to diff when complete, so no partial value is ever visible
  logic [WIDTH-1:0]       work_q, work_nxt;
  logic [WIDTH+DIGIT-1:0] work_cat;
  logic                   bin_q;
  logic [CW-1:0]          count;
  logic                   last;

  logic [DIGIT-1:0]       a_dig, b_dig, d_dig;
  logic                   br;
  logic                   bout;
  logic                   ovf_dig;

  assign a_dig = a_q[DIGIT-1:0];
  assign b_dig = b_q[DIGIT-1:0];
  assign last  = (count == CW'(N - 1));

  // DIGIT-bit ripple-borrow subtract of the current digit pair
  always_comb begin
    d_dig = '0;
    br    = bin_q;
    for (int i = 0; i < DIGIT; i++) begin
      d_dig[i] = a_dig[i] ^ b_dig[i] ^ br;
      br       = (~a_dig[i] & (b_dig[i] | br)) | (b_dig[i] & br);
    end
    bout = br;
  end

  // New digit enters at the top of the work register; after N digits it is fully aligned.
  // On the last digit the operand MSBs sit at the top of a_dig/b_dig, which gives ovf directly.
  always_comb begin
    work_cat = {d_dig, work_q};
    work_nxt = work_cat[WIDTH+DIGIT-1:DIGIT];
    ovf_dig  = (a_dig[DIGIT-1] != b_dig[DIGIT-1]) && (d_dig[DIGIT-1] != a_dig[DIGIT-1]);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept in IDLE, N digit cycles in BUSY, hold in DONE until consumed
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture operands, step one digit per BUSY cycle, publish result on the last digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      work_q <= '0;
      bin_q  <= 1'b0;
      count  <= '0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            bin_q <= 1'b0;
            count <= '0;
          end
        end
        BUSY: begin
          a_q    <= a_q >> DIGIT;
          b_q    <= b_q >> DIGIT;
          work_q <= work_nxt;
          bin_q  <= bout;
          count  <= last ? '0 : count + 1'b1;
          if (last) begin
            diff   <= work_nxt;
            borrow <= bout;
            ovf    <= ovf_dig;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at DIGIT=4, 1 and 32
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a, b;

  logic        in_ready  [3];
  logic        out_valid [3];
  logic        borrow    [3];
  logic        ovf       [3];
  logic [31:0] diff      [3];

  int n_cmp = 0;
  int n_mis = 0;
  int lat_exp [3] = '{8, 32, 1};
  int dig     [3] = '{4, 1, 32};

  serial_subtractor #(.WIDTH(32), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready),
    .diff(diff[0]), .borrow(borrow[0]), .ovf(ovf[0])
  );

  serial_subtractor #(.WIDTH(32), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready),
    .diff(diff[1]), .borrow(borrow[1]), .ovf(ovf[1])
  );

  serial_subtractor #(.WIDTH(32), .DIGIT(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a(a), .b(b), .out_valid(out_valid[2]), .out_ready(out_ready),
    .diff(diff[2]), .borrow(borrow[2]), .ovf(ovf[2])
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string where);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_d%0d_in_ready", where, dig[i]), 32'(in_ready[i]), 32'd1);
      chk($sformatf("%s_d%0d_out_valid", where, dig[i]), 32'(out_valid[i]), 32'd0);
      chk($sformatf("%s_d%0d_diff", where, dig[i]), diff[i], 32'd0);
      chk($sformatf("%s_d%0d_borrow", where, dig[i]), 32'(borrow[i]), 32'd0);
      chk($sformatf("%s_d%0d_ovf", where, dig[i]), 32'(ovf[i]), 32'd0);
    end
  endtask

  // One transaction on all three instances; hold = extra backpressure cycles after all are valid
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int hold);
    logic [31:0] ed;
    logic        eb, eo;
    longint      s;
    int          lat [3];
    ed = av - bv;
    eb = (av < bv);
    s  = longint'($signed(av)) - longint'($signed(bv));
    eo = (s > 64'sd2147483647) || (s < -64'sd2147483648);

    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    // Operands change after the accept edge and in_valid stays high: neither may matter
    a = $urandom; b = $urandom;
    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int i = 0; i < 3; i++)
      chk($sformatf("busy_d%0d_in_ready", dig[i]), 32'(in_ready[i]), 32'd0);

    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++)
        if (lat[i] == 0 && out_valid[i] === 1'b1) lat[i] = cyc;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_latency", dig[i]), 32'(lat[i]), 32'(lat_exp[i]));
      chk($sformatf("d%0d_diff a=%0h b=%0h", dig[i], av, bv), diff[i], ed);
      chk($sformatf("d%0d_borrow a=%0h b=%0h", dig[i], av, bv), 32'(borrow[i]), 32'(eb));
      chk($sformatf("d%0d_ovf a=%0h b=%0h", dig[i], av, bv), 32'(ovf[i]), 32'(eo));
    end

    repeat (hold) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("bp_d%0d_out_valid", dig[i]), 32'(out_valid[i]), 32'd1);
        chk($sformatf("bp_d%0d_in_ready", dig[i]), 32'(in_ready[i]), 32'd0);
        chk($sformatf("bp_d%0d_diff", dig[i]), diff[i], ed);
        chk($sformatf("bp_d%0d_borrow", dig[i]), 32'(borrow[i]), 32'(eb));
      end
    end

    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rel_d%0d_out_valid", dig[i]), 32'(out_valid[i]), 32'd0);
      chk($sformatf("rel_d%0d_in_ready", dig[i]), 32'(in_ready[i]), 32'd1);
      chk($sformatf("rel_d%0d_diff_held", dig[i]), diff[i], ed);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd5, 32'd3, 0);
    run_op(32'd0, 32'd1, 0);
    run_op(32'h8000_0000, 32'd1, 0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 5);

    // Abort in BUSY at count=3 (DIGIT=32 instance is already in DONE)
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd100, 32'd40, 0);

    run_op(32'h1234_5678, 32'h1234_5678, 0);
    run_op(32'hFFFF_FFFF, 32'd0, 0);
    for (int k = 0; k < 10; k++) run_op($urandom, $urandom, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
